// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Purpose  : Round-robin arbiter and command sequencer that shares one burst
//            RAM between an instruction-side requester (port 0) and a
//            data-side requester (port 1). It issues a one-cycle command,
//            tracks the 8-beat read burst or the single write acknowledge,
//            steers read beats to the owner, and inserts a cool-down cycle
//            so the RAM is idle before the next command.
// Optional : ARB_TIMEOUT_EN - adds a watchdog on the WAIT states. On expiry
//            it ends the transaction with done+err. Without it, err_o is 0.
// Ports    : clk, rst_n            - clock, async active-low reset
//            req_i[1:0]            - per-port request, held until done
//            req_rnw_i[1:0]        - per-port direction (1 = read)
//            gnt_o[1:0]            - one-hot owner, grant through done cycle
//            rvalid_o[1:0]         - per-port read-beat strobe
//            rdata_o               - read beat data
//            done_o[1:0]           - one-cycle completion pulse
//            err_o[1:0]            - one-cycle timeout pulse (with done)
//            ram_avalid_o          - RAM command strobe
//            ram_rnw_o             - RAM command direction
//            ram_ack_i             - RAM read beat / write completion
//            ram_rdata_i           - RAM read data
// Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
    parameter int DATA_W  = 8,
    parameter int BEATS   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_i,
    input  logic [1:0]        req_rnw_i,
    output logic [1:0]        gnt_o,
    output logic [1:0]        rvalid_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic [1:0]        done_o,
    output logic [1:0]        err_o,
    output logic              ram_avalid_o,
    output logic              ram_rnw_o,
    input  logic              ram_ack_i,
    input  logic [DATA_W-1:0] ram_rdata_i
);

    localparam int               CNT_W     = (BEATS > 2) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT_RD = 3'd2,
        S_WAIT_WR = 3'd3,
        S_COOL    = 3'd4
    } state_t;

    state_t              state_q;
    logic                owner_q;
    logic                rnw_q;
    logic                last_q;     // port served most recently
    logic                rd_last_q;  // final beat taken; done goes out next
    logic [CNT_W-1:0]    beat_q;
    logic [1:0]          gnt_q;
    logic [1:0]          rvalid_q;
    logic [1:0]          done_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                avalid_q;
    logic                ram_rnw_q;
    logic                owner_d;
    logic                wd_expired;

`ifdef ARB_TIMEOUT_EN
    localparam int              WD_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    logic [WD_W-1:0] wdog_q;
    logic [1:0]      err_q;

    // Expires on the TIMEOUT-th WAIT cycle so done/err land TIMEOUT cycles
    // after WAIT was entered.
    assign wd_expired = (wdog_q == WD_LAST);
    assign err_o      = err_q;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT;
    assign wd_expired     = 1'b0;
    assign err_o          = 2'b00;
`endif

    // Round-robin pick: on a tie the port not served last wins; a lone
    // requester wins regardless of the pointer.
    always_comb begin
        owner_d = 1'b0;
        if (req_i == 2'b11) begin
            owner_d = ~last_q;
        end else if (req_i[1]) begin
            owner_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            owner_q   <= 1'b0;
            rnw_q     <= 1'b0;
            last_q    <= 1'b1;
            rd_last_q <= 1'b0;
            beat_q    <= '0;
            gnt_q     <= 2'b00;
            rvalid_q  <= 2'b00;
            done_q    <= 2'b00;
            rdata_q   <= '0;
            avalid_q  <= 1'b0;
            ram_rnw_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            wdog_q    <= '0;
            err_q     <= 2'b00;
`endif
        end else begin
            rvalid_q <= 2'b00;
            done_q   <= 2'b00;
            avalid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            err_q    <= 2'b00;
            if (state_q == S_WAIT_RD || state_q == S_WAIT_WR) begin
                wdog_q <= wdog_q + 1'b1;
            end
`endif
            case (state_q)
                S_IDLE: begin
                    // Stale acks from a RAM that missed our reset are ignored here.
                    if (|req_i) begin
                        owner_q   <= owner_d;
                        rnw_q     <= req_rnw_i[owner_d];
                        gnt_q     <= owner_d ? 2'b10 : 2'b01;
                        avalid_q  <= 1'b1;
                        ram_rnw_q <= req_rnw_i[owner_d];
                        state_q   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    beat_q    <= '0;
                    rd_last_q <= 1'b0;
                    ram_rnw_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
                    wdog_q    <= '0;
`endif
                    state_q   <= rnw_q ? S_WAIT_RD : S_WAIT_WR;
                end
                S_WAIT_RD: begin
                    if (rd_last_q) begin
                        // Extra cycle lets the last rvalid go out before done.
                        done_q[owner_q] <= 1'b1;
                        state_q         <= S_COOL;
                    end else begin
                        if (ram_ack_i) begin
                            rdata_q          <= ram_rdata_i;
                            rvalid_q[owner_q] <= 1'b1;
                            beat_q           <= beat_q + 1'b1;
                            if (beat_q == LAST_BEAT) begin
                                rd_last_q <= 1'b1;
                            end
                        end
                        if (wd_expired) begin
                            done_q[owner_q] <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                            err_q[owner_q]  <= 1'b1;
`endif
                            state_q         <= S_COOL;
                        end
                    end
                end
                S_WAIT_WR: begin
                    if (ram_ack_i || wd_expired) begin
                        done_q[owner_q] <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                        err_q[owner_q]  <= ~ram_ack_i;
`endif
                        state_q         <= S_COOL;
                    end
                end
                S_COOL: begin
                    gnt_q   <= 2'b00;
                    last_q  <= owner_q;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt_o        = gnt_q;
    assign rvalid_o     = rvalid_q;
    assign rdata_o      = rdata_q;
    assign done_o       = done_q;
    assign ram_avalid_o = avalid_q;
    assign ram_rnw_o    = ram_rnw_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_arbiter
// Purpose  : Self-checking bench for ram_arbiter. A behavioural RAM answers
//            commands with random data; a round-robin reference model
//            predicts grant order; a monitor checks commands, beats and
//            completions against the predictions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req   = 2'b00;
    logic [1:0] req_rnw = 2'b00;
    logic [1:0] gnt, rvalid, done, err;
    logic [7:0] rdata;
    logic       ram_avalid, ram_rnw;
    logic       ram_ack   = 1'b0;
    logic [7:0] ram_rdata = 8'h00;

    always #5 clk = ~clk;

    ram_arbiter #(.DATA_W(8), .BEATS(8), .TIMEOUT(64)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_i        (req),
        .req_rnw_i    (req_rnw),
        .gnt_o        (gnt),
        .rvalid_o     (rvalid),
        .rdata_o      (rdata),
        .done_o       (done),
        .err_o        (err),
        .ram_avalid_o (ram_avalid),
        .ram_rnw_o    (ram_rnw),
        .ram_ack_i    (ram_ack),
        .ram_rdata_i  (ram_rdata)
    );

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Scoreboard queues
    logic [1:0] cmd_q[$];   // {port, rnw} per expected command
    logic [7:0] beat_q[$];  // data per expected read beat
    int         done_q[$];  // port per expected completion
    bit         track = 1'b1;

    // Monitor state
    logic cur_owner = 1'b0;
    logic cur_rnw   = 1'b0;
    int   cur_beats = 0;
    int   avalid_cyc = 0;
    int   done_cyc  = -100;

    // Behavioural RAM: read beats start two cycles after the command and run
    // eight consecutive cycles; a write acks ten cycles after the command.
    initial begin
        forever begin
            @(negedge clk);
            if (ram_avalid === 1'b1) begin
                if (ram_rnw) begin
                    @(posedge clk);
                    @(posedge clk);
                    #1;
                    for (int i = 0; i < 8; i++) begin
                        ram_ack   = 1'b1;
                        ram_rdata = 8'($urandom);
                        if (track) beat_q.push_back(ram_rdata);
                        @(posedge clk);
                        #1;
                    end
                    ram_ack = 1'b0;
                end else begin
                    repeat (10) @(posedge clk);
                    #1;
                    ram_ack   = 1'b1;
                    ram_rdata = 8'($urandom);
                    @(posedge clk);
                    #1;
                    ram_ack = 1'b0;
                end
            end
        end
    end

    // Monitor
    initial begin
        logic [1:0] e;
        logic [7:0] d;
        int         p;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (ram_avalid) begin
                    if (cmd_q.size() == 0) begin
                        check("unexpected_cmd", 32'(ram_avalid), 0);
                    end else begin
                        e         = cmd_q.pop_front();
                        cur_owner = e[1];
                        cur_rnw   = e[0];
                        cur_beats = 0;
                        check("cmd_rnw", 32'(ram_rnw), 32'(e[0]));
                        check("cmd_gnt", 32'(gnt), 32'(1 << e[1]));
                        check("cmd_gap", 32'(cyc - done_cyc >= 2), 1);
                        avalid_cyc = cyc;
                    end
                end
                if (gnt != 2'b00) check("gnt_onehot", 32'($countones(gnt)), 1);
                if (rvalid != 2'b00) begin
                    if (beat_q.size() == 0) begin
                        check("unexpected_beat", 32'(rvalid), 0);
                    end else begin
                        d = beat_q.pop_front();
                        check("beat_port", 32'(rvalid), 32'(1 << cur_owner));
                        check("beat_data", 32'(rdata), 32'(d));
                        cur_beats++;
                    end
                end
                if (done != 2'b00) begin
                    if (done_q.size() == 0) begin
                        check("unexpected_done", 32'(done), 0);
                    end else begin
                        p = done_q.pop_front();
                        check("done_port", 32'(done), 32'(1 << p));
                        check("done_latency", 32'(cyc - avalid_cyc), 11);
                        check("err_clear", 32'(err), 0);
                        check("gnt_at_done", 32'(gnt), 32'(1 << p));
                        if (cur_rnw) check("burst_len", 32'(cur_beats), 8);
                        done_cyc = cyc;
                    end
                end
            end
        end
    end

    // Reference round-robin model: pointer starts at port 1.
    int last_srv = 1;

    task automatic wait_done(int p);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done[p] && n < 300);
        if (!done[p]) check("done_timeout", 0, 1);
    endtask

    task automatic do_round(logic [1:0] mask, logic [1:0] rnw_bits, bit early);
        int order[$];
        if (mask == 2'b11) begin
            order.push_back(1 - last_srv);
            order.push_back(last_srv);
        end else begin
            order.push_back(mask == 2'b01 ? 0 : 1);
        end
        foreach (order[i]) begin
            cmd_q.push_back({1'(order[i]), rnw_bits[order[i]]});
            done_q.push_back(order[i]);
        end
        last_srv = order[order.size() - 1];
        req_rnw = rnw_bits;
        req     = mask;
        foreach (order[i]) begin
            if (early && order[i] == 0 && rnw_bits[0]) begin
                int cnt = 0;
                int n   = 0;
                while (cnt < 3 && n < 200) begin
                    @(negedge clk);
                    n++;
                    if (rvalid[0]) cnt++;
                end
                check("early_drop_beats", 32'(cnt), 3);
                req[0] = 1'b0;
            end
            wait_done(order[i]);
            req[order[i]] = 1'b0;
        end
        @(negedge clk);
        check("gnt_release", 32'(gnt), 0);
    endtask

    // Stimulus
    initial begin
        #12;
        check("rst_gnt",    32'(gnt), 0);
        check("rst_rvalid", 32'(rvalid), 0);
        check("rst_rdata",  32'(rdata), 0);
        check("rst_done",   32'(done), 0);
        check("rst_err",    32'(err), 0);
        check("rst_avalid", 32'(ram_avalid), 0);
        check("rst_rnw",    32'(ram_rnw), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_round(2'b01, 2'b01, 1'b0);   // port 0 read alone
        do_round(2'b10, 2'b00, 1'b0);   // port 1 write alone
        do_round(2'b11, 2'b11, 1'b0);   // contention: 0 then 1
        do_round(2'b11, 2'b11, 1'b0);   // contention: 0 then 1 again
        do_round(2'b11, 2'b11, 1'b1);   // port 0 drops req mid-burst

        for (int r = 0; r < 12; r++) begin
            do_round(2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)), 1'b0);
        end

        // Reset during beat 4 of a port 0 read
        begin
            int cnt = 0;
            int n   = 0;
            cmd_q.push_back(2'b01);
            req_rnw = 2'b01;
            req     = 2'b01;
            while (cnt < 3 && n < 200) begin
                @(negedge clk);
                n++;
                if (rvalid[0]) cnt++;
            end
            check("rst_setup_beats", 32'(cnt), 3);
            track = 1'b0;
            #1 rst_n = 1'b0;
            #1;
            check("arst_gnt",    32'(gnt), 0);
            check("arst_rvalid", 32'(rvalid), 0);
            check("arst_rdata",  32'(rdata), 0);
            check("arst_done",   32'(done), 0);
            check("arst_avalid", 32'(ram_avalid), 0);
            req = 2'b00;
            cmd_q.delete();
            beat_q.delete();
            done_q.delete();
            done_cyc = -100;
            last_srv = 1;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            repeat (12) @(negedge clk);
            track = 1'b1;
            do_round(2'b10, 2'b00, 1'b0);
        end

        check("queues_drained", 32'(cmd_q.size() + beat_q.size() + done_q.size()), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
